// File: rtl/peak_tx_pkg.sv
// Shared types and helpers for the peak-aligned burst transmitter.
// Holds the FSM state encoding, the missed-peak counter width and the delay arithmetic.
package peak_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int MISSED_CNT_W = 8;

    // Remaining samples until burst start; one extra bit lets "already past the target" show as a borrow.
    function automatic logic [31:0] sat_diff(input logic [31:0] target, input logic [31:0] elapsed);
        logic [32:0] diff;
        diff = {1'b0, target} - {1'b0, elapsed};
        if (diff[32]) begin
            return '0;
        end
        return diff[31:0];
    endfunction

endpackage

// File: rtl/peak_tx_countdown.sv
// Sample-strobe down-counter for the peak-to-burst delay.
// Load has priority over decrement; the count holds at zero.
module peak_tx_countdown #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/peak_burst_tx.sv
// Peak-aligned burst transmitter: after a detector peak, waits out the programmed delay and passes one burst_len burst.
// Build option PEAK_BURST_TX_RETRIG_EN: a peak during the countdown re-arms instead of being counted as missed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | outputs gated, waiting for a peak to arm
// ST_WAIT | counting sample strobes down to the burst start
// ST_SEND | zero-latency pass-through until the last beat transfers
module peak_burst_tx
    import peak_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DELAY_WIDTH = 16,
    parameter int LEN_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [DELAY_WIDTH-1:0]  delay,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic                    sample_stb,
    input  logic                    peak_stb_in,
    input  logic [DATA_WIDTH-1:0]   nrx_after_peak,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready,
    output logic                    busy,
    output logic                    late,
    output logic [MISSED_CNT_W-1:0] missed_cnt
);

    state_t                  state;
    state_t                  state_nxt;
    logic [LEN_WIDTH-1:0]    beat;
    logic [LEN_WIDTH-1:0]    last_idx;
    logic                    late_q;
    logic [MISSED_CNT_W-1:0] missed_q;

    logic [DELAY_WIDTH-1:0]  d_val;
    logic                    peak_due;
    logic                    peak_late;
    logic                    arm;
    logic                    peak_missed;
    logic                    xfer;
    logic                    last_beat;
    logic                    cd_load;
    logic                    cd_dec;
    logic [DELAY_WIDTH-1:0]  cd_count;
    logic                    cd_zero;

    // The difference never exceeds delay, so it always fits the countdown width.
    assign d_val     = DELAY_WIDTH'(sat_diff(32'(delay), 32'(nrx_after_peak)));
    assign peak_due  = (d_val == '0);
    assign peak_late = (32'(nrx_after_peak) > 32'(delay));
    assign last_beat = (beat == last_idx);

    peak_tx_countdown #(
        .WIDTH (DELAY_WIDTH)
    ) u_countdown (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (cd_load),
        .load_val (d_val),
        .dec      (cd_dec),
        .count    (cd_count),
        .zero     (cd_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            beat     <= '0;
            last_idx <= '0;
            late_q   <= 1'b0;
            missed_q <= '0;
        end else if (clear) begin
            state    <= ST_IDLE;
            beat     <= '0;
            last_idx <= '0;
            late_q   <= 1'b0;
            missed_q <= '0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                late_q   <= peak_late;
                last_idx <= (burst_len == '0) ? '0 : burst_len - 1'b1;
            end
            if (xfer) begin
                beat <= last_beat ? '0 : beat + 1'b1;
            end
            if (peak_missed && (missed_q != '1)) begin
                missed_q <= missed_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        arm         = 1'b0;
        peak_missed = 1'b0;
        cd_load     = 1'b0;
        cd_dec      = 1'b0;
        xfer        = 1'b0;
        in_tready   = 1'b0;
        out_tvalid  = 1'b0;
        out_tdata   = '0;
        out_tlast   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (peak_stb_in) begin
                    arm = 1'b1;
                    if (peak_due) begin
                        state_nxt = ST_SEND;
                    end else begin
                        cd_load   = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cd_dec = sample_stb;
                // The zero term only guards against a stranded counter; arming never loads zero.
                if ((sample_stb && (cd_count == DELAY_WIDTH'(1))) || cd_zero) begin
                    state_nxt = ST_SEND;
                end
`ifdef PEAK_BURST_TX_RETRIG_EN
                if (peak_stb_in) begin
                    arm    = 1'b1;
                    cd_dec = 1'b0;
                    if (peak_due) begin
                        state_nxt = ST_SEND;
                    end else begin
                        cd_load   = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
`else
                peak_missed = peak_stb_in;
`endif
            end
            ST_SEND: begin
                in_tready   = out_tready;
                out_tvalid  = in_tvalid;
                out_tdata   = in_tdata;
                out_tlast   = last_beat;
                xfer        = in_tvalid && out_tready;
                peak_missed = peak_stb_in;
                if (xfer && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign late       = late_q;
    assign missed_cnt = missed_q;

endmodule

// File: tb/tb_peak_burst_tx.sv
// Directed self-checking bench for peak_burst_tx: timing, late arming, backpressure, missed peaks, reset mid-burst.
module tb_peak_burst_tx;

    localparam int DW  = 16;
    localparam int DLW = 16;
    localparam int LW  = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic [DLW-1:0] delay;
    logic [LW-1:0]  burst_len;
    logic           sample_stb;
    logic           peak_stb_in;
    logic [DW-1:0]  nrx_after_peak;
    logic [DW-1:0]  in_tdata;
    logic           in_tvalid;
    logic           in_tready;
    logic [DW-1:0]  out_tdata;
    logic           out_tvalid;
    logic           out_tlast;
    logic           out_tready;
    logic           busy;
    logic           late;
    logic [7:0]     missed_cnt;

    logic [DW-1:0]  src_data = 16'h0100;
    logic [DW-1:0]  rx_d[$];
    bit             rx_l[$];
    int             n_cmp = 0;
    int             n_err = 0;

    peak_burst_tx #(
        .DATA_WIDTH  (DW),
        .DELAY_WIDTH (DLW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .delay          (delay),
        .burst_len      (burst_len),
        .sample_stb     (sample_stb),
        .peak_stb_in    (peak_stb_in),
        .nrx_after_peak (nrx_after_peak),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .out_tdata      (out_tdata),
        .out_tvalid     (out_tvalid),
        .out_tlast      (out_tlast),
        .out_tready     (out_tready),
        .busy           (busy),
        .late           (late),
        .missed_cnt     (missed_cnt)
    );

    always #5 clk = ~clk;

    // Source: a counting sequence that advances only on a handshake.
    assign in_tdata = src_data;
    always @(posedge clk) begin
        if (in_tvalid && in_tready) src_data <= src_data + 1'b1;
    end

    // Sink monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && out_tvalid && out_tready) begin
            rx_d.push_back(out_tdata);
            rx_l.push_back(out_tlast);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Count of deviations from an n-beat burst d0, d0+1, ... with tlast only on the final beat.
    function automatic int burst_errs(input logic [DW-1:0] d0, input int n);
        int e = 0;
        if (rx_d.size() != n) e++;
        for (int i = 0; i < rx_d.size(); i++) begin
            if (rx_d[i] !== d0 + DW'(i)) e++;
            if (rx_l[i] !== (i == n - 1)) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        reset = 1'b0; clear = 1'b0; sample_stb = 1'b0; peak_stb_in = 1'b0;
        delay = '0; burst_len = 12'd8; nrx_after_peak = '0;
        in_tvalid = 1'b1; out_tready = 1'b1;
        repeat (3) step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL reset_in_tready: got %0b want 0", in_tready); end
        n_cmp++; if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) begin n_err++; $display("FAIL reset_out: valid %0b last %0b want 0 0", out_tvalid, out_tlast); end
        n_cmp++; if (out_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", out_tdata); end
        n_cmp++; if (late !== 1'b0 || missed_cnt !== 8'd0) begin n_err++; $display("FAIL reset_flags: late %0b missed %0d want 0 0", late, missed_cnt); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_nominal;
        int strobes = 0;
        int c_last = -1;
        int c_got = -1;
        int cyc = 0;
        logic [DW-1:0] d0;
        delay = 16'd20; nrx_after_peak = 16'd5; burst_len = 12'd8;
        rx_d.delete(); rx_l.delete();
        d0 = src_data;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (busy !== 1'b1 || out_tvalid !== 1'b0) begin n_err++; $display("FAIL nom_wait: busy %0b valid %0b want 1 0", busy, out_tvalid); end
        for (int c = 0; c < 200; c++) begin
            if (out_tvalid) begin c_got = c; break; end
            sample_stb = (c % 5 == 4);
            if (sample_stb) begin strobes++; c_last = c; end
            step();
        end
        sample_stb = 1'b0;
        n_cmp++; if (strobes !== 15) begin n_err++; $display("FAIL nom_strobes: got %0d want 15", strobes); end
        n_cmp++; if (c_got !== c_last + 1) begin n_err++; $display("FAIL nom_send_start: got cycle %0d want %0d", c_got, c_last + 1); end
        n_cmp++; if (late !== 1'b0 || out_tdata !== d0) begin n_err++; $display("FAIL nom_first: late %0b data %h want 0 %h", late, out_tdata, d0); end
        while (busy && cyc < 50) begin step(); cyc++; end
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL nom_busy_drop: got %0d cycles want 8", cyc); end
        n_cmp++; if (burst_errs(d0, 8) !== 0) begin n_err++; $display("FAIL nom_burst: got %0d beats %0d errors want 8 0", rx_d.size(), burst_errs(d0, 8)); end
    endtask

    task automatic test_late;
        bit ok;
        burst_len = 12'd8;
        delay = 16'd4; nrx_after_peak = 16'd9;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (out_tvalid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL late_send: valid %0b busy %0b want 1 1", out_tvalid, busy); end
        n_cmp++; if (late !== 1'b1) begin n_err++; $display("FAIL late_flag: got %0b want 1", late); end
        drain(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL late_drain: got %0b want 1", ok); end
        delay = 16'd9; nrx_after_peak = 16'd9;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (out_tvalid !== 1'b1 || late !== 1'b0) begin n_err++; $display("FAIL ontime_send: valid %0b late %0b want 1 0", out_tvalid, late); end
        drain(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ontime_drain: got %0b want 1", ok); end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] d0;
        int c = 0;
        delay = '0; nrx_after_peak = '0; burst_len = 12'd8;
        rx_d.delete(); rx_l.delete();
        d0 = src_data;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        while (busy && c < 400) begin
            out_tready = (c % 2 == 0);
            in_tvalid  = 1'($urandom_range(0, 1));
            #1;
            n_cmp++; if (in_tready !== out_tready) begin n_err++; $display("FAIL bp_ready_mirror: got %0b want %0b", in_tready, out_tready); end
            step();
            c++;
        end
        in_tvalid = 1'b1; out_tready = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done: busy %0b want 0", busy); end
        n_cmp++; if (burst_errs(d0, 8) !== 0) begin n_err++; $display("FAIL bp_burst: got %0d beats %0d errors want 8 0", rx_d.size(), burst_errs(d0, 8)); end
    endtask

    task automatic test_second_peak;
        int strobes = 0;
        bit ok;
        int want_strobes;
        logic [7:0] want_missed;
`ifdef PEAK_BURST_TX_RETRIG_EN
        want_strobes = 5; want_missed = 8'd0;
`else
        want_strobes = 10; want_missed = 8'd1;
`endif
        do_reset();
        delay = 16'd20; nrx_after_peak = 16'd5;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        repeat (5) begin sample_stb = 1'b1; step(); end
        sample_stb = 1'b0;
        nrx_after_peak = 16'd15;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (missed_cnt !== want_missed) begin n_err++; $display("FAIL second_missed: got %0d want %0d", missed_cnt, want_missed); end
        for (int c = 0; c < 100; c++) begin
            if (out_tvalid) break;
            sample_stb = 1'b1; strobes++;
            step();
        end
        sample_stb = 1'b0;
        n_cmp++; if (strobes !== want_strobes) begin n_err++; $display("FAIL second_timing: got %0d strobes want %0d", strobes, want_strobes); end
        drain(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL second_drain: got %0b want 1", ok); end
    endtask

    task automatic test_reset_mid_burst;
        logic [DW-1:0] d0;
        int nl = 0;
        bit ok;
        do_reset();
        delay = 16'd3; nrx_after_peak = 16'd7; burst_len = 12'd8;
        rx_d.delete(); rx_l.delete();
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        step(); step();
        n_cmp++; if (late !== 1'b1 || missed_cnt !== 8'd1) begin n_err++; $display("FAIL rmb_pre: late %0b missed %0d want 1 1", late, missed_cnt); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || out_tlast !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmb_gate: ready %0b valid %0b last %0b busy %0b want 0 0 0 0", in_tready, out_tvalid, out_tlast, busy);
        end
        n_cmp++; if (out_tdata !== '0 || late !== 1'b0 || missed_cnt !== 8'd0) begin
            n_err++; $display("FAIL rmb_regs: data %h late %0b missed %0d want 0 0 0", out_tdata, late, missed_cnt);
        end
        foreach (rx_l[i]) nl += int'(rx_l[i]);
        n_cmp++; if (rx_d.size() !== 3 || nl !== 0) begin n_err++; $display("FAIL rmb_partial: got %0d beats %0d tlast want 3 0", rx_d.size(), nl); end
        step();
        reset = 1'b1;
        rx_d.delete(); rx_l.delete();
        d0 = src_data;
        delay = '0; nrx_after_peak = '0;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        drain(ok);
        n_cmp++; if (ok !== 1'b1 || burst_errs(d0, 8) !== 0) begin n_err++; $display("FAIL rmb_fresh: done %0b beats %0d errors %0d want 1 8 0", ok, rx_d.size(), burst_errs(d0, 8)); end
    endtask

    task automatic test_clear;
        delay = 16'd100; nrx_after_peak = '0;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_armed: busy %0b want 1", busy); end
        clear = 1'b1; step(); clear = 1'b0;
        n_cmp++; if (busy !== 1'b0 || out_tvalid !== 1'b0) begin n_err++; $display("FAIL clear_idle: busy %0b valid %0b want 0 0", busy, out_tvalid); end
    endtask

    task automatic test_saturate_and_len0;
        logic [DW-1:0] d0;
        do_reset();
        delay = '0; nrx_after_peak = '0; burst_len = 12'd8;
        out_tready = 1'b0;
        peak_stb_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) begin
                n_cmp++; if (missed_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", missed_cnt); end
            end
        end
        peak_stb_in = 1'b0;
        n_cmp++; if (missed_cnt !== 8'd255 || busy !== 1'b1) begin n_err++; $display("FAIL sat_255: missed %0d busy %0b want 255 1", missed_cnt, busy); end
        out_tready = 1'b1;
        do_reset();
        burst_len = '0;
        rx_d.delete(); rx_l.delete();
        d0 = src_data;
        peak_stb_in = 1'b1; step(); peak_stb_in = 1'b0;
        n_cmp++; if (out_tlast !== 1'b1 || out_tvalid !== 1'b1) begin n_err++; $display("FAIL len0_last: last %0b valid %0b want 1 1", out_tlast, out_tvalid); end
        step();
        n_cmp++; if (busy !== 1'b0 || burst_errs(d0, 1) !== 0) begin n_err++; $display("FAIL len0_burst: busy %0b beats %0d want 0 1", busy, rx_d.size()); end
        burst_len = 12'd8;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_late();
        test_backpressure();
        test_second_peak();
        test_reset_mid_burst();
        test_clear();
        test_saturate_and_len0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
